// File: rtl/clk_freq_monitor_pkg.sv
// Shared constants and state encoding for the divided-clock frequency monitor.
package clk_freq_monitor_pkg;

  localparam int HALF_4F_DEF  = 4;
  localparam int HALF_2F_DEF  = 8;
  localparam int HALF_F_DEF   = 16;
  localparam int LOCK_CNT_DEF = 4;
  localparam int CNT_W_DEF    = 6;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } chk_state_e;

endpackage

// File: rtl/clk_run_checker.sv
// Measures high/low run lengths of one divided clock against its expected half-period.
//   state   | meaning
//   SEARCH  | waiting for the first edge; partial run before it is ignored
//   MEASURE | counting consecutive good half-periods towards lock
//   LOCKED  | lock asserted; every run must still be exactly HALF samples
//   FAULT   | violation seen; waits for an edge to restart measurement
module clk_run_checker
  import clk_freq_monitor_pkg::*;
#(
  parameter int HALF     = HALF_4F_DEF,
  parameter int LOCK_CNT = LOCK_CNT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic clk_32f,
  input  logic reset,
  input  logic err_clr,
  input  logic clk_in,
  output logic lock,
  output logic err
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]  HALF_C    = CNT_W'(HALF);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [GOOD_W-1:0] LAST_GOOD = GOOD_W'(LOCK_CNT - 1);

  logic              s_q;
  logic [CNT_W-1:0]  run_q;
  logic [GOOD_W-1:0] good_q, good_d;
  chk_state_e        state_q, state_d;
  logic              edge_seen, good_run, short_run, long_run, violation;

  assign edge_seen = clk_in != s_q;
  assign good_run  = edge_seen && (run_q == HALF_C);
  assign short_run = edge_seen && (run_q < HALF_C);
  // Overlong run is flagged on the (HALF+1)-th sample, not when the edge finally arrives
  assign long_run  = !edge_seen && (run_q == HALF_C);

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      s_q   <= 1'b0;
      run_q <= '0;
    end else begin
      s_q <= clk_in;
      if (edge_seen)
        run_q <= CNT_W'(1);
      else if (run_q != CNT_MAX)
        run_q <= run_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    violation = 1'b0;
    case (state_q)
      SEARCH: begin
        if (edge_seen) begin
          state_d = MEASURE;
          good_d  = '0;
        end
      end
      MEASURE: begin
        if (short_run || long_run) begin
          state_d   = FAULT;
          violation = 1'b1;
        end else if (good_run) begin
          good_d = good_q + 1'b1;
          if (good_q == LAST_GOOD)
            state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (short_run || long_run) begin
          state_d   = FAULT;
          violation = 1'b1;
        end
      end
      FAULT: begin
        if (edge_seen) begin
          state_d = MEASURE;
          good_d  = '0;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_q <= SEARCH;
      good_q  <= '0;
      lock    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      lock    <= (state_d == LOCKED);
      err     <= violation | (err & ~err_clr);
    end
  end

endmodule

// File: rtl/clk_freq_monitor.sv
// Checks clk_4f/clk_2f/clk_f half-periods against clk_32f and reports per-clock lock and sticky errors.
module clk_freq_monitor
  import clk_freq_monitor_pkg::*;
#(
  parameter int HALF_4F  = HALF_4F_DEF,
  parameter int HALF_2F  = HALF_2F_DEF,
  parameter int HALF_F   = HALF_F_DEF,
  parameter int LOCK_CNT = LOCK_CNT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic clk_32f,
  input  logic reset,
  input  logic err_clr,
  input  logic clk_4f,
  input  logic clk_2f,
  input  logic clk_f,
  output logic lock_4f,
  output logic lock_2f,
  output logic lock_f,
  output logic err_4f,
  output logic err_2f,
  output logic err_f,
  output logic all_lock
);

  clk_run_checker #(.HALF(HALF_4F), .LOCK_CNT(LOCK_CNT), .CNT_W(CNT_W)) u_chk_4f (
    .clk_32f (clk_32f),
    .reset   (reset),
    .err_clr (err_clr),
    .clk_in  (clk_4f),
    .lock    (lock_4f),
    .err     (err_4f)
  );

  clk_run_checker #(.HALF(HALF_2F), .LOCK_CNT(LOCK_CNT), .CNT_W(CNT_W)) u_chk_2f (
    .clk_32f (clk_32f),
    .reset   (reset),
    .err_clr (err_clr),
    .clk_in  (clk_2f),
    .lock    (lock_2f),
    .err     (err_2f)
  );

  clk_run_checker #(.HALF(HALF_F), .LOCK_CNT(LOCK_CNT), .CNT_W(CNT_W)) u_chk_f (
    .clk_32f (clk_32f),
    .reset   (reset),
    .err_clr (err_clr),
    .clk_in  (clk_f),
    .lock    (lock_f),
    .err     (err_f)
  );

  // Registered so downstream gating sees a clean flop output
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset)
      all_lock <= 1'b0;
    else
      all_lock <= lock_4f & lock_2f & lock_f;
  end

endmodule
